nor_flash_ctrl: RTL and testbench

//   Host-side command controller that sits directly upstream of nor_flash_memory and drives its
//   we/re/address/data_in pins. Accepts READ, PROGRAM and SECTOR-ERASE requests over a valid/ready

---
 rtl/nor_flash_ctrl_if.sv | 26 ++
 rtl/nor_flash_ctrl.sv | 116 +++++++++++
 tb/tb_nor_flash_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nor_flash_ctrl_if.sv
// Host-side request/response channel of the NOR flash command controller.
// The host drives requests and consumes responses; the controller is the slave.
interface nor_flash_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/nor_flash_ctrl.sv
// NOR flash command controller: READ, PROGRAM (read-modify-write, bits only clear)
// and SECTOR ERASE, one operation in flight, one response per request.
module nor_flash_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int SECTOR_WORDS = 16,
    parameter int READ_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    nor_flash_ctrl_if.slave   bus,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;
    localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [ADDR_W-1:0] SEC_MASK = ADDR_W'(SECTOR_WORDS - 1);

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, PG_RD, PG_WAIT, PG_WR, ER, RESP} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] wdata_q;
    logic [CW-1:0]     cnt;
    logic [LW-1:0]     lat_cnt;
    logic              accept;
    logic              lat_done;
    logic              cnt_done;
    logic [DATA_W-1:0] merged;

    assign accept   = bus.req_valid && (state == IDLE);
    assign lat_done = (lat_cnt == LW'(READ_LAT - 1));
    assign cnt_done = (cnt == CW'(SECTOR_WORDS - 1));
    assign merged   = mem_rdata & wdata_q;

    // Strobes are pure state decodes so reset removes them without waiting for an edge.
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign mem_we        = (state == PG_WR) || (state == ER);
    assign mem_re        = (state == RD) || (state == PG_RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                case (bus.req_op)
                    2'b00:   state_nxt = RD;
                    2'b01:   state_nxt = PG_RD;
                    2'b10:   state_nxt = ER;
                    default: state_nxt = RESP;
                endcase
            end
            RD:      state_nxt = RD_WAIT;
            RD_WAIT: if (lat_done) state_nxt = RESP;
            PG_RD:   state_nxt = PG_WAIT;
            PG_WAIT: if (lat_done) state_nxt = PG_WR;
            PG_WR:   state_nxt = RESP;
            ER:      if (cnt_done) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr      <= '0;
            mem_wdata     <= '0;
            wdata_q       <= '0;
            cnt           <= '0;
            lat_cnt       <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    // Erase starts at the sector base; everything else targets the word itself.
                    mem_addr      <= (bus.req_op == 2'b10) ? (bus.req_addr & ~SEC_MASK) : bus.req_addr;
                    mem_wdata     <= (bus.req_op == 2'b10) ? '1 : '0;
                    wdata_q       <= bus.req_wdata;
                    cnt           <= '0;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= (bus.req_op == 2'b11);
                end
                RD, PG_RD: lat_cnt <= '0;
                RD_WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_done) begin
                        bus.rsp_rdata <= mem_rdata;
                        bus.rsp_err   <= 1'b0;
                    end
                end
                PG_WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_done) begin
                        mem_wdata     <= merged;
                        bus.rsp_rdata <= merged;
                        bus.rsp_err   <= (merged != wdata_q);
                    end
                end
                // Base is sector-aligned and cnt stops at the last word, so +1 stays in the sector.
                ER: if (!cnt_done) begin
                    cnt      <= cnt + 1'b1;
                    mem_addr <= mem_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nor_flash_ctrl.sv
// Directed bench for nor_flash_ctrl: behavioural NOR memory, reference model and a
// response scoreboard; memory-port traffic is logged for per-operation checks.
module tb_nor_flash_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nor_flash_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus();

    logic       mem_we, mem_re;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    nor_flash_ctrl #(.ADDR_W(8), .DATA_W(8), .SECTOR_WORDS(16), .READ_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct packed {logic [7:0] a; logic [7:0] d; logic [31:0] c;} wlog_t;
    typedef struct {logic [7:0] rdata; logic err;} exp_t;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [31:0] cyc = 0;
    int          re_cnt = 0;
    int          viol = 0;
    wlog_t       we_log[$];
    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] acc_cyc;

    // Memory with one cycle of read latency; also the bus monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_log.push_back('{mem_addr, mem_wdata, cyc});
        end
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
            re_cnt    <= re_cnt + 1;
        end
        if (mem_we && mem_re) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd);
        exp_t e;
        logic [7:0] base;
        int k;
        case (op)
            2'b00: begin e.rdata = ref_mem[a]; e.err = 1'b0; end
            2'b01: begin
                e.rdata = ref_mem[a] & wd;
                e.err   = (e.rdata != wd);
                ref_mem[a] = e.rdata;
            end
            2'b10: begin
                base = a & 8'hF0;
                for (int i = 0; i < 16; i++) ref_mem[base + 8'(i)] = 8'hFF;
                e.rdata = 8'h00; e.err = 1'b0;
            end
            default: begin e.rdata = 8'h00; e.err = 1'b1; end
        endcase
        sb.push_back(e);
        k = 0;
        @(negedge clk);
        while (!bus.req_ready && k < 50) begin @(negedge clk); k++; end
        if (!bus.req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        acc_cyc       = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input int hold, output int lat);
        exp_t e;
        int k, re0, we0;
        k = 0;
        lat = 0;
        @(negedge clk);
        while (!bus.rsp_valid && k < 100) begin @(negedge clk); k++; end
        if (!bus.rsp_valid) begin
            chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
            return;
        end
        lat = int'(cyc - acc_cyc) + 1;
        e = sb.pop_front();
        chk({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(e.rdata));
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
        re0 = re_cnt;
        we0 = we_log.size();
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, 32'(bus.rsp_rdata), 32'(e.rdata));
            chk({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        if (hold > 0) begin
            chk({tag, "_hold_re"}, 32'(re_cnt - re0), 32'd0);
            chk({tag, "_hold_we"}, 32'(we_log.size() - we0), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, re0, we0, k;
        logic [7:0] v;
        logic [7:0] saved [16];
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        rst_n = 1'b1;

        // 1: erase sector 0, then read back; latency counts the accept edge as the first
        we_log.delete();
        re0 = re_cnt;
        send(2'b10, 8'h03, 8'h00);
        get_rsp("er0", 0, lat);
        chk("er0_we_count", 32'(we_log.size()), 32'd16);
        chk("er0_re_count", 32'(re_cnt - re0), 32'd0);
        for (int i = 0; i < we_log.size() && i < 16; i++) begin
            chk("er0_addr", 32'(we_log[i].a), 32'(i));
            chk("er0_data", 32'(we_log[i].d), 32'h FF);
        end
        if (we_log.size() == 16) chk("er0_contiguous", we_log[15].c - we_log[0].c, 32'd15);
        send(2'b00, 8'h05, 8'h00);
        get_rsp("rd05_a", 0, lat);
        chk("rd05_latency", 32'(lat), 32'd3);

        // 2: program 0xAB over erased word
        we_log.delete();
        re0 = re_cnt;
        send(2'b01, 8'h05, 8'hAB);
        get_rsp("pg05_ab", 0, lat);
        chk("pg05_ab_re", 32'(re_cnt - re0), 32'd1);
        chk("pg05_ab_we", 32'(we_log.size()), 32'd1);
        if (we_log.size() > 0) begin
            chk("pg05_ab_waddr", 32'(we_log[0].a), 32'h05);
            chk("pg05_ab_wdata", 32'(we_log[0].d), 32'hAB);
        end
        send(2'b00, 8'h05, 8'h00);
        get_rsp("rd05_b", 0, lat);

        // 3: program needing 0->1 bits: write still happens, err flagged
        we_log.delete();
        send(2'b01, 8'h05, 8'hF0);
        get_rsp("pg05_f0", 0, lat);
        chk("pg05_f0_we", 32'(we_log.size()), 32'd1);
        if (we_log.size() > 0) chk("pg05_f0_wdata", 32'(we_log[0].d), 32'hA0);
        send(2'b00, 8'h05, 8'h00);
        get_rsp("rd05_c", 0, lat);

        // 4: erase sector 1 leaves sector 0 alone
        we_log.delete();
        send(2'b10, 8'h13, 8'h00);
        get_rsp("er1", 0, lat);
        chk("er1_we_count", 32'(we_log.size()), 32'd16);
        if (we_log.size() == 16) begin
            chk("er1_first", 32'(we_log[0].a), 32'h10);
            chk("er1_last", 32'(we_log[15].a), 32'h1F);
        end
        send(2'b00, 8'h05, 8'h00);
        get_rsp("rd05_d", 0, lat);
        send(2'b00, 8'h1F, 8'h00);
        get_rsp("rd1f", 0, lat);

        // 5: response back-pressure, then illegal op
        send(2'b00, 8'h1F, 8'h00);
        get_rsp("rd1f_hold", 5, lat);
        we_log.delete();
        re0 = re_cnt;
        send(2'b11, 8'h42, 8'h55);
        get_rsp("illegal", 0, lat);
        chk("illegal_re", 32'(re_cnt - re0), 32'd0);
        chk("illegal_we", 32'(we_log.size()), 32'd0);

        // 6: reset in the middle of an erase
        send(2'b01, 8'h26, 8'h00);
        get_rsp("pg26", 0, lat);
        for (int i = 0; i < 16; i++) saved[i] = ref_mem[8'h20 + 8'(i)];
        send(2'b10, 8'h20, 8'h00);
        k = 0;
        @(negedge clk);
        while (!(mem_we && mem_addr == 8'h24) && k < 40) begin @(negedge clk); k++; end
        chk("er2_reached_cnt4", 32'(mem_we && mem_addr == 8'h24), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("er2_rst_we", 32'(mem_we), 32'd0);
        chk("er2_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("er2_rst_valid", 32'(bus.rsp_valid), 32'd0);
        sb.delete();
        for (int i = 4; i < 16; i++) ref_mem[8'h20 + 8'(i)] = saved[i];
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b00, 8'h26, 8'h00);
        get_rsp("rd26", 0, lat);
        send(2'b00, 8'h24, 8'h00);
        get_rsp("rd24", 0, lat);
        send(2'b00, 8'h23, 8'h00);
        get_rsp("rd23", 0, lat);

        chk("we_re_overlap", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
